// File: rtl/instr_load_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// instr_load_arbiter_pkg
// Shared types for the instruction-register load arbiter: the register's
// opcode/operand/address types, the arbiter state encoding and the payload
// bundle carried from a requester to the register write port.
// No ports (package).
// -----------------------------------------------------------------------------
package instr_load_arbiter_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  localparam int ADDR_W = $bits(address_t);
  localparam int SLOTS  = 2**ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } arb_state_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } req_payload_t;

endpackage

// File: rtl/instr_load_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. The search starts at the priority pointer and walks
// upward with wrap; the first active request wins. The pointer moves to the
// position after the winner only when the grant is actually accepted.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   i_clear       synchronous return of the priority pointer to 0
//   i_req         request vector
//   i_accept      the current grant is taken this cycle
//   o_grant       one-hot grant (zero when no request)
//   o_idx         index of the granted request
//   o_any         at least one request is active
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_clear,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_accept,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0]   r_prio;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;

  always_comb begin
    int j;
    w_grant = '0;
    w_idx   = '0;
    w_any   = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(r_prio) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_any && i_req[j]) begin
        w_any      = 1'b1;
        w_idx      = IDX_W'(j);
        w_grant[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prio <= '0;
    end else if (i_clear) begin
      r_prio <= '0;
    end else if (i_accept && w_any) begin
      r_prio <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
    end
  end

  assign o_grant = w_grant;
  assign o_idx   = w_idx;
  assign o_any   = w_any;

endmodule

// File: rtl/instr_load_arbiter.sv
// -----------------------------------------------------------------------------
// instr_load_arbiter
// Shares the instruction register's single write port between NUM_REQ
// valid/ready requesters. Requests are granted round-robin, each accepted
// payload is written one cycle later to the next sequential slot, and the
// winning requester id accompanies the write strobe.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   clear               synchronous clear of pointer, count and priority
//   req_valid/ready     per-requester handshake (ready is combinational)
//   req_opcode/operand_a/operand_b  per-requester payload
//   load_en             one-cycle write strobe per accepted transfer
//   opcode/operand_a/operand_b/write_pointer  registered write-port drive
//   grant_id            requester owning the current load_en
//   count, full         occupied slots (saturating at DEPTH), count == DEPTH
//   overwrite           pulses with load_en when an occupied slot is reused
// -----------------------------------------------------------------------------
module instr_load_arbiter
  import instr_load_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int DEPTH   = 32,
  parameter  int WRAP    = 1,
  localparam int GID_W   = $clog2(NUM_REQ),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  opcode_t            req_opcode    [NUM_REQ],
  input  operand_t           req_operand_a [NUM_REQ],
  input  operand_t           req_operand_b [NUM_REQ],
  output logic               load_en,
  output opcode_t            opcode,
  output operand_t           operand_a,
  output operand_t           operand_b,
  output address_t           write_pointer,
  output logic [GID_W-1:0]   grant_id,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               overwrite
);

  arb_state_t         r_state;
  logic               r_load_en;
  logic               r_overwrite;
  req_payload_t       r_payload;
  address_t           r_wptr;
  address_t           r_alloc;
  logic [GID_W-1:0]   r_gid;
  logic [CNT_W-1:0]   r_count;

  logic [NUM_REQ-1:0] w_grant;
  logic [GID_W-1:0]   w_idx;
  logic               w_any;
  logic               w_en;
  logic               w_xfer;
  logic               w_cnt_full;
  logic               w_will_fill;
  req_payload_t       w_sel;

  // Reset is folded in so ready is low while reset_n is asserted, even though
  // the handshake itself is combinational.
  assign w_en        = reset_n && !clear && (r_state != FULL);
  assign w_xfer      = w_en && w_any;
  assign w_cnt_full  = (r_count == CNT_W'(DEPTH));
  // Only the non-wrapping variant blocks; it must stop on the transfer that
  // fills the last slot so no ready is issued once count reaches DEPTH.
  assign w_will_fill = (WRAP == 0) && w_xfer && (r_count == CNT_W'(DEPTH - 1));

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (clear),
    .i_req    (req_valid),
    .i_accept (w_en),
    .o_grant  (w_grant),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  assign req_ready = w_grant & {NUM_REQ{w_en}};

  always_comb begin
    w_sel      = '0;
    w_sel.opc  = req_opcode[w_idx];
    w_sel.op_a = req_operand_a[w_idx];
    w_sel.op_b = req_operand_b[w_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_load_en   <= 1'b0;
      r_overwrite <= 1'b0;
      r_payload   <= '0;
      r_wptr      <= '0;
      r_alloc     <= '0;
      r_gid       <= '0;
      r_count     <= '0;
    end else begin
      r_load_en   <= w_xfer;
      r_overwrite <= w_xfer && (WRAP != 0) && w_cnt_full;
      if (w_xfer) begin
        r_payload <= w_sel;
        r_wptr    <= r_alloc;
        r_gid     <= w_idx;
      end
      if (clear) begin
        r_alloc <= '0;
        r_count <= '0;
        r_state <= IDLE;
      end else begin
        if (w_xfer) begin
          r_alloc <= r_alloc + address_t'(1);
          if (!w_cnt_full) r_count <= r_count + CNT_W'(1);
        end
        unique case (r_state)
          IDLE: begin
            if (w_will_fill)     r_state <= FULL;
            else if (|req_valid) r_state <= LOAD;
          end
          LOAD: begin
            if (w_will_fill)       r_state <= FULL;
            else if (!(|req_valid)) r_state <= IDLE;
          end
          FULL:    r_state <= FULL;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign load_en       = r_load_en;
  assign overwrite     = r_overwrite;
  assign opcode        = r_payload.opc;
  assign operand_a     = r_payload.op_a;
  assign operand_b     = r_payload.op_b;
  assign write_pointer = r_wptr;
  assign grant_id      = r_gid;
  assign count         = r_count;
  assign full          = w_cnt_full;

endmodule

// File: tb/tb_instr_load_arbiter.sv
// -----------------------------------------------------------------------------
// tb_instr_load_arbiter
// Drives a wrapping (index 0) and a non-wrapping (index 1) arbiter from the
// same stimulus and compares both against a cycle reference model, plus a
// table of hand-computed vectors and directed corner-case sequences.
// -----------------------------------------------------------------------------
module tb_instr_load_arbiter;
  import instr_load_arbiter_pkg::*;

  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic clr   = 1'b0;
  logic [NR-1:0] valid = '0;
  opcode_t  t_opc [NR];
  operand_t t_a   [NR];
  operand_t t_b   [NR];

  logic [NR-1:0] rdy [2];
  logic          ld  [2];
  opcode_t       opc [2];
  operand_t      oa  [2];
  operand_t      ob  [2];
  address_t      wp  [2];
  logic [0:0]    gid [2];
  logic [5:0]    cnt [2];
  logic          fl  [2];
  logic          ov  [2];

  always #5 clk = ~clk;

  instr_load_arbiter #(.NUM_REQ(NR), .DEPTH(DEPTH), .WRAP(1)) u_wrap (
    .clk(clk), .reset_n(rst_n), .clear(clr), .req_valid(valid), .req_ready(rdy[0]),
    .req_opcode(t_opc), .req_operand_a(t_a), .req_operand_b(t_b),
    .load_en(ld[0]), .opcode(opc[0]), .operand_a(oa[0]), .operand_b(ob[0]),
    .write_pointer(wp[0]), .grant_id(gid[0]), .count(cnt[0]), .full(fl[0]),
    .overwrite(ov[0]));

  instr_load_arbiter #(.NUM_REQ(NR), .DEPTH(DEPTH), .WRAP(0)) u_stop (
    .clk(clk), .reset_n(rst_n), .clear(clr), .req_valid(valid), .req_ready(rdy[1]),
    .req_opcode(t_opc), .req_operand_a(t_a), .req_operand_b(t_b),
    .load_en(ld[1]), .opcode(opc[1]), .operand_a(oa[1]), .operand_b(ob[1]),
    .write_pointer(wp[1]), .grant_id(gid[1]), .count(cnt[1]), .full(fl[1]),
    .overwrite(ov[1]));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: per-instance priority, allocation pointer and count,
  // plus the expected registered write-port values.
  int       m_prio [2];
  int       m_ptr  [2];
  int       m_cnt  [2];
  logic     e_ld   [2];
  logic     e_ov   [2];
  opcode_t  e_opc  [2];
  operand_t e_a    [2];
  operand_t e_b    [2];
  int       e_wp   [2];
  int       e_gid  [2];
  logic [NR-1:0] last_rdy [2];

  // Captured contents of the instruction register fed by the wrapping instance.
  opcode_t  mem_op [DEPTH];
  operand_t mem_a  [DEPTH];
  operand_t mem_b  [DEPTH];

  function automatic operand_t exec(opcode_t o, operand_t a, operand_t b);
    case (o)
      PASSA:   return a;
      PASSB:   return b;
      ADD:     return a + b;
      SUB:     return a - b;
      MULT:    return a * b;
      DIV:     return (b != 0) ? a / b : 0;
      MOD:     return (b != 0) ? a % b : 0;
      default: return 0;
    endcase
  endfunction

  // Instance 1 does not wrap: once every slot is occupied it accepts nothing.
  function automatic int winner(int d);
    if (clr) return -1;
    if (d == 1 && m_cnt[d] == DEPTH) return -1;
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_prio[d] + k) % NR;
      if (valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_prio[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
      e_ld[d] = 1'b0; e_ov[d] = 1'b0; e_opc[d] = ZERO;
      e_a[d] = 0; e_b[d] = 0; e_wp[d] = 0; e_gid[d] = 0;
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      int w;
      w = winner(d);
      e_ld[d] = (w >= 0);
      e_ov[d] = (w >= 0) && (d == 0) && (m_cnt[d] == DEPTH);
      if (w >= 0) begin
        e_opc[d] = t_opc[w]; e_a[d] = t_a[w]; e_b[d] = t_b[w];
        e_wp[d]  = m_ptr[d]; e_gid[d] = w;
        m_ptr[d] = (m_ptr[d] + 1) % DEPTH;
        if (m_cnt[d] < DEPTH) m_cnt[d]++;
        m_prio[d] = (w + 1) % NR;
      end
      if (clr) begin
        m_ptr[d] = 0; m_cnt[d] = 0; m_prio[d] = 0;
      end
    end
  endtask

  task automatic check_ready();
    for (int d = 0; d < 2; d++) begin
      logic [NR-1:0] e;
      int w;
      e = '0;
      w = winner(d);
      if (w >= 0) e[w] = 1'b1;
      last_rdy[d] = rdy[d];
      chk($sformatf("d%0d req_ready", d), rdy[d], e);
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d load_en", d), ld[d], e_ld[d]);
      chk($sformatf("d%0d opcode", d), opc[d], e_opc[d]);
      chk($sformatf("d%0d operand_a", d), oa[d], e_a[d]);
      chk($sformatf("d%0d operand_b", d), ob[d], e_b[d]);
      chk($sformatf("d%0d write_pointer", d), wp[d], e_wp[d]);
      chk($sformatf("d%0d grant_id", d), gid[d], e_gid[d]);
      chk($sformatf("d%0d count", d), cnt[d], m_cnt[d]);
      chk($sformatf("d%0d full", d), fl[d], m_cnt[d] == DEPTH);
      chk($sformatf("d%0d overwrite", d), ov[d], e_ov[d]);
    end
    if (ld[0]) begin
      mem_op[wp[0]] = opc[0]; mem_a[wp[0]] = oa[0]; mem_b[wp[0]] = ob[0];
    end
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic cycle();
    #1;
    check_ready();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d rst load_en", d), ld[d], 0);
      chk($sformatf("d%0d rst opcode", d), opc[d], ZERO);
      chk($sformatf("d%0d rst operand_a", d), oa[d], 0);
      chk($sformatf("d%0d rst operand_b", d), ob[d], 0);
      chk($sformatf("d%0d rst write_pointer", d), wp[d], 0);
      chk($sformatf("d%0d rst grant_id", d), gid[d], 0);
      chk($sformatf("d%0d rst count", d), cnt[d], 0);
      chk($sformatf("d%0d rst full", d), fl[d], 0);
      chk($sformatf("d%0d rst overwrite", d), ov[d], 0);
      chk($sformatf("d%0d rst req_ready", d), rdy[d], 0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0] v;
    logic       c;
    opcode_t    o0; int a0; int b0;
    opcode_t    o1; int a1; int b1;
    logic [1:0] rdy;
    logic       ld;
    opcode_t    eo; int ea; int eb;
    int         ewp; int egid; int ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] v, input logic c,
                     input opcode_t o0, input int a0, input int b0,
                     input opcode_t o1, input int a1, input int b1,
                     input logic [1:0] r, input logic l,
                     input opcode_t eo, input int ea, input int eb,
                     input int ewp, input int egid, input int ecnt);
    vec_t x;
    x.v = v; x.c = c; x.o0 = o0; x.a0 = a0; x.b0 = b0; x.o1 = o1; x.a1 = a1; x.b1 = b1;
    x.rdy = r; x.ld = l; x.eo = eo; x.ea = ea; x.eb = eb;
    x.ewp = ewp; x.egid = egid; x.ecnt = ecnt;
    tbl.push_back(x);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      t_opc[i] = ZERO; t_a[i] = 0; t_b[i] = 0;
    end
    #2;
    do_reset();

    // valid clr | req0 payload | req1 payload | ready ld | expected write port | wp gid count
    add(2'b10, 1'b0, ZERO, 0, 0, ADD,  5, 7, 2'b10, 1'b1, ADD,  5, 7, 0, 1, 1);
    add(2'b00, 1'b0, ZERO, 0, 0, ZERO, 0, 0, 2'b00, 1'b0, ADD,  5, 7, 0, 1, 1);
    add(2'b01, 1'b1, SUB,  9, 3, ZERO, 0, 0, 2'b00, 1'b0, ADD,  5, 7, 0, 1, 0);
    add(2'b01, 1'b0, SUB,  9, 3, ZERO, 0, 0, 2'b01, 1'b1, SUB,  9, 3, 0, 0, 1);
    add(2'b00, 1'b1, ZERO, 0, 0, ZERO, 0, 0, 2'b00, 1'b0, SUB,  9, 3, 0, 0, 0);
    add(2'b11, 1'b0, MULT, 2, 3, DIV,  8, 4, 2'b01, 1'b1, MULT, 2, 3, 0, 0, 1);
    add(2'b11, 1'b0, MULT, 2, 3, DIV,  8, 4, 2'b10, 1'b1, DIV,  8, 4, 1, 1, 2);
    add(2'b11, 1'b0, MULT, 2, 3, DIV,  8, 4, 2'b01, 1'b1, MULT, 2, 3, 2, 0, 3);
    add(2'b11, 1'b0, MULT, 2, 3, DIV,  8, 4, 2'b10, 1'b1, DIV,  8, 4, 3, 1, 4);
    add(2'b00, 1'b0, ZERO, 0, 0, ZERO, 0, 0, 2'b00, 1'b0, DIV,  8, 4, 3, 1, 4);

    for (int r = 0; r < tbl.size(); r++) begin
      valid = tbl[r].v; clr = tbl[r].c;
      t_opc[0] = tbl[r].o0; t_a[0] = tbl[r].a0; t_b[0] = tbl[r].b0;
      t_opc[1] = tbl[r].o1; t_a[1] = tbl[r].a1; t_b[1] = tbl[r].b1;
      cycle();
      chk($sformatf("tbl%0d ready", r), last_rdy[0], tbl[r].rdy);
      chk($sformatf("tbl%0d load_en", r), ld[0], tbl[r].ld);
      chk($sformatf("tbl%0d opcode", r), opc[0], tbl[r].eo);
      chk($sformatf("tbl%0d operand_a", r), oa[0], tbl[r].ea);
      chk($sformatf("tbl%0d operand_b", r), ob[0], tbl[r].eb);
      chk($sformatf("tbl%0d write_pointer", r), wp[0], tbl[r].ewp);
      chk($sformatf("tbl%0d grant_id", r), gid[0], tbl[r].egid);
      chk($sformatf("tbl%0d count", r), cnt[0], tbl[r].ecnt);
      if (r == 0)
        chk("slot0 readback result", exec(mem_op[0], mem_a[0], mem_b[0]), 12);
    end
    clr = 1'b0;

    // Reset while a load is on the write port, then the first write lands in slot 0.
    valid = 2'b01; t_opc[0] = PASSA; t_a[0] = 42; t_b[0] = 1;
    cycle();
    chk("pre-reset load_en", ld[0], 1);
    do_reset();
    valid = 2'b10; t_opc[1] = ADD; t_a[1] = 1; t_b[1] = 2;
    cycle();
    chk("post-reset load_en", ld[0], 1);
    chk("post-reset write_pointer", wp[0], 0);

    // Fill all slots with one requester holding valid.
    valid = 2'b00; clr = 1'b1;
    cycle();
    clr = 1'b0; valid = 2'b01;
    for (int i = 0; i < DEPTH; i++) begin
      t_opc[0] = opcode_t'($urandom_range(0, 7));
      t_a[0] = operand_t'($urandom); t_b[0] = operand_t'($urandom);
      cycle();
    end
    chk("wrap count at 32", cnt[0], 32);
    chk("wrap full at 32", fl[0], 1);
    chk("stop count at 32", cnt[1], 32);
    chk("stop full at 32", fl[1], 1);
    cycle();
    chk("wrap 33rd write_pointer", wp[0], 0);
    chk("wrap 33rd overwrite", ov[0], 1);
    chk("wrap 33rd count", cnt[0], 32);
    chk("stop ready while full", last_rdy[1], 0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("stop held ready", last_rdy[1], 0);
      chk("stop held load_en", ld[1], 0);
    end
    clr = 1'b1;
    cycle();
    chk("stop clear count", cnt[1], 0);
    clr = 1'b0;
    cycle();
    chk("stop after clear load_en", ld[1], 1);
    chk("stop after clear write_pointer", wp[1], 0);
    chk("stop after clear count", cnt[1], 1);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      valid = NR'($urandom);
      clr = ($urandom_range(0, 63) == 0);
      for (int q = 0; q < NR; q++) begin
        t_opc[q] = opcode_t'($urandom_range(0, 7));
        t_a[q] = operand_t'($urandom); t_b[q] = operand_t'($urandom);
      end
      cycle();
      if (i == 300) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
